// File: rtl/nios_ii_seq_bank_pkg.sv
// Shared address map and CTRL/STATUS bit positions for the step-sequencer bank.
package seq_pkg;

    localparam logic [4:0] ADDR_CTRL         = 5'd0;
    localparam logic [4:0] ADDR_STATUS       = 5'd1;
    localparam logic [4:0] ADDR_PATTERN_BASE = 5'd16;

    localparam int CTRL_RUN_BIT     = 0;
    localparam int CTRL_RESTART_BIT = 1;
    localparam int CTRL_IRQ_EN_BIT  = 2;
    localparam int CTRL_LEN_LSB     = 8;
    localparam int CTRL_LEN_MSB     = 12;
    localparam int STATUS_WRAP_BIT  = 31;

endpackage

// File: rtl/nios_ii_seq_bank_step_counter.sv
// Step counter: advances on a gated tick, wraps past len_m1, restart forces step 0.
module seq_step_counter (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       advance,
    input  logic       restart,
    input  logic [4:0] len_m1,
    output logic [4:0] step,
    output logic       wrap
);

    // A step beyond a freshly shrunk len_m1 also wraps, hence >= rather than ==.
    assign wrap = advance && !restart && (step >= len_m1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            step <= 5'd0;
        end else if (restart) begin
            step <= 5'd0;
        end else if (advance) begin
            step <= wrap ? 5'd0 : step + 5'd1;
        end
    end

endmodule

// File: rtl/nios_ii_seq_bank.sv
// Avalon-MM trigger sequencer bank: per-track step patterns fired on a tempo tick.
// Optional wrap interrupt is built only when SEQ_IRQ_EN is defined.
module nios_ii_seq_bank
    import seq_pkg::*;
#(
    parameter int NUM_TRACKS = 8,
    parameter int STEPS_MAX  = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [4:0]            address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [31:0]           writedata,
    output logic [31:0]           readdata,
    input  logic                  step_tick,
    output logic [NUM_TRACKS-1:0] trig_out,
    output logic [4:0]            step_out,
    output logic                  irq
);

    logic        write_en;
    logic        ctrl_wr;
    logic        status_wr;
    logic        restart;
    logic        advance;
    logic        wrap;
    logic        run;
    logic        irq_en;
    logic [4:0]  len_m1;
    logic [4:0]  step;
    logic [7:0]  len_wr;
    logic [31:0] pattern [NUM_TRACKS];
    logic        wrap_flag;

    assign write_en  = chipselect && !write_n;
    assign ctrl_wr   = write_en && (address == ADDR_CTRL);
    assign status_wr = write_en && (address == ADDR_STATUS);
    assign restart   = ctrl_wr && writedata[CTRL_RESTART_BIT];
    assign advance   = step_tick && run;
    assign step_out  = step;

    // The length byte is read as 15:8 so that values spilling into the reserved
    // bits above the field saturate instead of silently aliasing.
    assign len_wr = writedata[15:8];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            run    <= 1'b0;
            irq_en <= 1'b0;
            len_m1 <= 5'(STEPS_MAX - 1);
        end else if (ctrl_wr) begin
            run    <= writedata[CTRL_RUN_BIT];
            irq_en <= writedata[CTRL_IRQ_EN_BIT];
            len_m1 <= (len_wr > 8'(STEPS_MAX - 1)) ? 5'(STEPS_MAX - 1) : len_wr[4:0];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int t = 0; t < NUM_TRACKS; t++) pattern[t] <= 32'd0;
        end else begin
            for (int t = 0; t < NUM_TRACKS; t++) begin
                if (write_en && (address == ADDR_PATTERN_BASE + 5'(t))) pattern[t] <= writedata;
            end
        end
    end

    seq_step_counter u_step_counter (
        .clk     (clk),
        .reset_n (reset_n),
        .advance (advance),
        .restart (restart),
        .len_m1  (len_m1),
        .step    (step),
        .wrap    (wrap)
    );

    // Triggers sample the pre-edge pattern, so a coincident rewrite fires the old value.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            trig_out <= '0;
        end else begin
            for (int t = 0; t < NUM_TRACKS; t++) begin
                trig_out[t] <= advance && !restart && ({1'b0, step} < 6'(STEPS_MAX))
                               && pattern[t][step];
            end
        end
    end

`ifdef SEQ_IRQ_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wrap_flag <= 1'b0;
        end else if (wrap) begin
            wrap_flag <= 1'b1;
        end else if (status_wr && writedata[STATUS_WRAP_BIT]) begin
            wrap_flag <= 1'b0;
        end
    end
    assign irq = wrap_flag && irq_en;
`else
    assign wrap_flag = 1'b0;
    assign irq       = 1'b0;
`endif

    always_comb begin
        readdata = 32'd0;
        if (address == ADDR_CTRL) begin
            readdata[CTRL_RUN_BIT]                   = run;
            readdata[CTRL_IRQ_EN_BIT]                = irq_en;
            readdata[CTRL_LEN_MSB:CTRL_LEN_LSB]      = len_m1;
        end else if (address == ADDR_STATUS) begin
            readdata[4:0]                            = step;
            readdata[STATUS_WRAP_BIT]                = wrap_flag;
        end else begin
            for (int t = 0; t < NUM_TRACKS; t++) begin
                if (address == ADDR_PATTERN_BASE + 5'(t)) readdata = pattern[t];
            end
        end
    end

endmodule
